// File: rtl/mem_word_loader_pkg.sv
// Shared definitions for the 16-bit word loader: FSM encoding, bus widths and
// the default ack timeout.
package mem_word_loader_pkg;

  localparam int BYTE_W      = 8;
  localparam int WORD_W      = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Little-endian assembly: high byte came from addr+1.
  function automatic logic [WORD_W-1:0] join_bytes(input logic [BYTE_W-1:0] hi,
                                                   input logic [BYTE_W-1:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/mem_word_loader_if.sv
// Request, byte-memory and response signals of the word loader. The slave
// modport is the loader; the master modport is everything around it.
interface mem_word_loader_if
  import mem_word_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [BYTE_W-1:0] mem_wdata;
  logic [BYTE_W-1:0] mem_rdata;
  logic              mem_ack;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_data;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  mem_rdata, mem_ack, rsp_ready,
    output req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
    output rsp_valid, rsp_data, rsp_err
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output mem_rdata, mem_ack, rsp_ready,
    input  req_ready, mem_addr, mem_rd, mem_wr, mem_wdata,
    input  rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/mem_word_loader_ack_timer.sv
// Per-beat wait counter. Flags expiry in the cycle that would be the
// TIMEOUT-th consecutive cycle without an ack.
module ack_timer
  import mem_word_loader_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic CLK,
  input  logic RES,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RES || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != CNT_W'(TIMEOUT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Enable is already gated by the absence of ack, so an ack in the limit cycle wins.
  assign o_expired = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/mem_word_loader.sv
// Splits one 16-bit load/store into two byte beats (low at addr, high at
// addr+1) and returns the assembled word, a store echo, or a timeout error.
module mem_word_loader
  import mem_word_loader_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             RES,
  mem_word_loader_if.slave bus
);

  state_e            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WORD_W-1:0] r_wdata;
  logic [BYTE_W-1:0] r_lo;

  logic              r_req_ready;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic [BYTE_W-1:0] r_mem_wdata;
  logic              r_rsp_valid;
  logic [WORD_W-1:0] r_rsp_data;
  logic              r_rsp_err;

  logic              w_in_beat;
  logic              w_tmr_clr;
  logic              w_tmr_en;
  logic              w_expired;

  assign w_in_beat = (r_state == ST_LO) || (r_state == ST_HI);
  // Clearing while idle or on ack means each beat starts from zero.
  assign w_tmr_clr = !w_in_beat || bus.mem_ack;
  assign w_tmr_en  = w_in_beat && !bus.mem_ack;

  ack_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .CLK       (CLK),
    .RES       (RES),
    .i_clr     (w_tmr_clr),
    .i_en      (w_tmr_en),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK) begin
    if (RES) begin
      r_state     <= ST_IDLE;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_lo        <= '0;
      r_req_ready <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_mem_wdata <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (r_req_ready && bus.req_valid) begin
            r_req_ready <= 1'b0;
            r_we        <= bus.req_we;
            r_addr      <= bus.req_addr;
            r_wdata     <= bus.req_wdata;
            r_mem_addr  <= bus.req_addr;
            r_mem_rd    <= !bus.req_we;
            r_mem_wr    <= bus.req_we;
            r_mem_wdata <= bus.req_wdata[BYTE_W-1:0];
            r_state     <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.mem_ack) begin
            r_lo        <= bus.mem_rdata;
            r_mem_addr  <= r_addr + ADDR_W'(1);
            r_mem_wdata <= r_wdata[WORD_W-1:BYTE_W];
            r_state     <= ST_HI;
          end else if (w_expired) begin
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_HI: begin
          if (bus.mem_ack || w_expired) begin
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
            if (bus.mem_ack) begin
              r_rsp_data <= r_we ? r_wdata : join_bytes(bus.mem_rdata, r_lo);
              r_rsp_err  <= 1'b0;
            end else begin
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_rd    = r_mem_rd;
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;

endmodule
